// File: rtl/tiger_wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
//   REGNUM_WIDTH / DATA_WIDTH : register file address / data widths
//   wb_state_e                : arbiter FSM states (NORMAL, FORCE)
//   rf_write_en()             : register-file write enable with r0 suppression
package tiger_wb_arbiter_pkg;

  localparam int unsigned REGNUM_WIDTH = 5;
  localparam int unsigned DATA_WIDTH   = 32;

  typedef logic [REGNUM_WIDTH-1:0] regnum_t;
  typedef logic [DATA_WIDTH-1:0]   data_t;

  typedef enum logic {
    WB_ST_NORMAL = 1'b0,
    WB_ST_FORCE  = 1'b1
  } wb_state_e;

  // A write to r0 is still consumed, but never reaches the register file
  // unless it is accompanied by a coprocessor write.
  function automatic logic rf_write_en(input logic we, input logic cop_we, input regnum_t regnum);
    return we && ((regnum != '0) || cop_we);
  endfunction

endpackage

// File: rtl/tiger_wb_fifo.sv
// Circular buffer of multi-cycle results {regnum, data}.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset (empties the buffer)
//   push, push_regnum, push_data: enqueue request and payload (ignored when full)
//   pop                         : dequeue request (ignored when empty)
//   head_regnum, head_data      : oldest entry
//   full, empty                 : occupancy flags
//   ent_valid, ent_regnum       : per-slot valid flag and destination, for hazard compare
module tiger_wb_fifo
  import tiger_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                push,
  input  logic [REGNUM_WIDTH-1:0]             push_regnum,
  input  logic [DATA_WIDTH-1:0]               push_data,
  input  logic                                pop,
  output logic [REGNUM_WIDTH-1:0]             head_regnum,
  output logic [DATA_WIDTH-1:0]               head_data,
  output logic                                full,
  output logic                                empty,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REGNUM_WIDTH-1:0]  ent_regnum
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]                     wr_ptr, rd_ptr;
  logic [PW:0]                       count;
  logic [DEPTH-1:0][REGNUM_WIDTH-1:0] regnum_q;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]   data_q;
  logic                              do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      regnum_q[wr_ptr] <= push_regnum;
      data_q[wr_ptr]   <= push_data;
    end
  end

  assign head_regnum = regnum_q[rd_ptr];
  assign head_data   = data_q[rd_ptr];
  assign ent_regnum  = regnum_q;

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    ent_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(i) - rd_ptr} < count);
    end
  end

endmodule

// File: rtl/tiger_wb_arbiter.sv
// Writeback arbiter: owns the single register-file write port, shared by the
// in-order pipeline writeback and a buffered multi-cycle unit. A starvation
// counter forces a pipeline stall so buffered results drain; pending
// destinations are exported to decode for hazard detection.
// Optional feature macro: TIGER_WB_BYPASS_EN -- a multi-cycle result arriving
// with the buffer empty and the pipeline idle goes straight to rf_* without
// being buffered.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   pipe_we, pipe_cop_we         : pipeline register / coprocessor write enables
//   pipe_regnum, pipe_data       : pipeline write address / data
//   mc_valid, mc_regnum, mc_data : multi-cycle result handshake and payload
//   mc_ready                     : buffer can accept a result
//   stall_pipe                   : pipeline must hold writeback while high
//   hz_regnum_a, hz_regnum_b     : decode source operands
//   hz_pending                   : a source operand has an uncommitted write
//   rf_we, rf_cop_we, rf_regnum, rf_data : registered register-file write port
module tiger_wb_arbiter
  import tiger_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pipe_we,
  input  logic                    pipe_cop_we,
  input  logic [REGNUM_WIDTH-1:0] pipe_regnum,
  input  logic [DATA_WIDTH-1:0]   pipe_data,
  input  logic                    mc_valid,
  output logic                    mc_ready,
  input  logic [REGNUM_WIDTH-1:0] mc_regnum,
  input  logic [DATA_WIDTH-1:0]   mc_data,
  output logic                    stall_pipe,
  input  logic [REGNUM_WIDTH-1:0] hz_regnum_a,
  input  logic [REGNUM_WIDTH-1:0] hz_regnum_b,
  output logic                    hz_pending,
  output logic                    rf_we,
  output logic                    rf_cop_we,
  output logic [REGNUM_WIDTH-1:0] rf_regnum,
  output logic [DATA_WIDTH-1:0]   rf_data
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_state_e                        state_q, state_d;
  logic [SW-1:0]                    starve_q, starve_d;

  logic                             fifo_full, fifo_empty, fifo_push, fifo_pop;
  regnum_t                          head_regnum;
  data_t                            head_data;
  logic [FIFO_DEPTH-1:0]            ent_valid;
  logic [FIFO_DEPTH-1:0][REGNUM_WIDTH-1:0] ent_regnum;

  logic                             sel_pipe, sel_fifo, sel_byp;
  logic                             rf_we_d, rf_cop_we_d;
  regnum_t                          rf_regnum_d;
  data_t                            rf_data_d;
  logic                             hit_a, hit_b;

  tiger_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (fifo_push),
    .push_regnum (mc_regnum),
    .push_data   (mc_data),
    .pop         (fifo_pop),
    .head_regnum (head_regnum),
    .head_data   (head_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .ent_valid   (ent_valid),
    .ent_regnum  (ent_regnum)
  );

  assign mc_ready = ~fifo_full;

  // Grant: the pipeline always wins, even in FORCE (a protocol violation is
  // tolerated rather than dropping a write); otherwise the buffer head.
  always_comb begin
    sel_pipe = pipe_we | pipe_cop_we;
    sel_fifo = ~sel_pipe & ~fifo_empty;
`ifdef TIGER_WB_BYPASS_EN
    sel_byp  = ~sel_pipe & fifo_empty & mc_valid;
`else
    sel_byp  = 1'b0;
`endif
    fifo_pop  = sel_fifo;
    fifo_push = mc_valid & ~fifo_full & ~sel_byp;
  end

  // Starvation counter: counts cycles the head loses to the pipeline; frozen
  // while FORCE is waiting for the pipeline to back off.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (sel_pipe && state_q == WB_ST_NORMAL && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= WB_ST_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_ST_NORMAL: if (starve_q == STARVE_MAX && !fifo_empty) state_d = WB_ST_FORCE;
      WB_ST_FORCE:  if (fifo_pop || fifo_empty)                state_d = WB_ST_NORMAL;
      default:      state_d = WB_ST_NORMAL;
    endcase
  end

  // FSM: outputs (decoded straight from the state flop)
  always_comb begin
    stall_pipe = (state_q == WB_ST_FORCE);
  end

  // Next write-port contents; address/data hold when nothing is granted.
  always_comb begin
    rf_we_d     = 1'b0;
    rf_cop_we_d = 1'b0;
    rf_regnum_d = rf_regnum;
    rf_data_d   = rf_data;
    if (sel_pipe) begin
      rf_we_d     = rf_write_en(pipe_we, pipe_cop_we, pipe_regnum);
      rf_cop_we_d = pipe_cop_we;
      rf_regnum_d = pipe_regnum;
      rf_data_d   = pipe_data;
    end else if (sel_fifo) begin
      rf_we_d     = rf_write_en(1'b1, 1'b0, head_regnum);
      rf_regnum_d = head_regnum;
      rf_data_d   = head_data;
    end else if (sel_byp) begin
      rf_we_d     = rf_write_en(1'b1, 1'b0, mc_regnum);
      rf_regnum_d = mc_regnum;
      rf_data_d   = mc_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we     <= 1'b0;
      rf_cop_we <= 1'b0;
      rf_regnum <= '0;
      rf_data   <= '0;
    end else begin
      rf_we     <= rf_we_d;
      rf_cop_we <= rf_cop_we_d;
      rf_regnum <= rf_regnum_d;
      rf_data   <= rf_data_d;
    end
  end

  // Hazard compare against buffered results and the not-yet-committed output.
  always_comb begin
    hit_a = (rf_we | rf_cop_we) && (rf_regnum == hz_regnum_a);
    hit_b = (rf_we | rf_cop_we) && (rf_regnum == hz_regnum_b);
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && ent_regnum[i] == hz_regnum_a) hit_a = 1'b1;
      if (ent_valid[i] && ent_regnum[i] == hz_regnum_b) hit_b = 1'b1;
    end
    hz_pending = (hit_a && hz_regnum_a != '0) || (hit_b && hz_regnum_b != '0);
  end

endmodule
